// File: rtl/medidor_multicanal.sv
// Multi-channel ultrasonic level meter: sequentially triggers each sensor, times its echo in cm,
// then derives the minimum valid distance and drives valve hysteresis and level alarms from it.
module medidor_multicanal #(
  parameter int N_SENSORES  = 3,
  parameter int DIST_W      = 12,
  parameter int TRIG_CICLOS = 500,
  parameter int CICLOS_CM   = 2941,
  parameter int MAX_CM      = 400,
  parameter int GAP_CICLOS  = 50000,
  parameter int DIST_ABRE   = 300,
  parameter int DIST_FECHA  = 50,
  parameter int DIST_ALTA   = 30,
  parameter int DIST_BAIXA  = 350
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic                         continuo,
  input  logic [N_SENSORES-1:0]        echo,
  output logic [N_SENSORES-1:0]        trigger,
  output logic [N_SENSORES*DIST_W-1:0] distancia,
  output logic [N_SENSORES-1:0]        valido,
  output logic [DIST_W-1:0]            dist_min,
  output logic                         erro_sensor,
  output logic                         abre_valvula,
  output logic                         fecha_valvula,
  output logic                         buzzer_alta,
  output logic                         buzzer_baixa,
  output logic                         pronto,
  output logic                         db_fim_medida,
  output logic [3:0]                   db_estado,
  output logic [3:0]                   db_sensor
);

  localparam int TIMEOUT_CICLOS = MAX_CM * CICLOS_CM;
  localparam int CNT_MAX_A = (TIMEOUT_CICLOS > GAP_CICLOS) ? TIMEOUT_CICLOS : GAP_CICLOS;
  localparam int CNT_MAX   = (CNT_MAX_A > TRIG_CICLOS) ? CNT_MAX_A : TRIG_CICLOS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = (N_SENSORES > 1) ? $clog2(N_SENSORES) : 1;

  localparam logic [CNT_W-1:0]  TRIG_FIM    = CNT_W'(TRIG_CICLOS - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_FIM = CNT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CNT_W-1:0]  CM_FIM      = CNT_W'(CICLOS_CM - 1);
  localparam logic [CNT_W-1:0]  GAP_FIM     = CNT_W'(GAP_CICLOS - 1);
  localparam logic [IDX_W-1:0]  IDX_ULT     = IDX_W'(N_SENSORES - 1);
  localparam logic [DIST_W-1:0] MAX_D       = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0] MAX_D_M1    = DIST_W'(MAX_CM - 1);
  localparam logic [DIST_W-1:0] ABRE_D      = DIST_W'(DIST_ABRE);
  localparam logic [DIST_W-1:0] FECHA_D     = DIST_W'(DIST_FECHA);
  localparam logic [DIST_W-1:0] ALTA_D      = DIST_W'(DIST_ALTA);
  localparam logic [DIST_W-1:0] BAIXA_D     = DIST_W'(DIST_BAIXA);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARMAZENA    = 4'd5,
    GAP         = 4'd6,
    AVALIA      = 4'd7,
    FIM         = 4'd8
  } estado_t;

  estado_t                              estado_q, estado_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [DIST_W-1:0]                    cm_q, cm_d;
  logic                                 timeout_q, timeout_d;
  logic [N_SENSORES-1:0]                sync1_q, sync2_q;
  logic [N_SENSORES-1:0][DIST_W-1:0]    dist_q, dist_d;
  logic [N_SENSORES-1:0]                valido_q, valido_d;
  logic [DIST_W-1:0]                    dist_min_q, dist_min_d;
  logic                                 erro_q, erro_d;
  logic                                 abre_q, abre_d;
  logic                                 fecha_q, fecha_d;
  logic                                 alta_q, alta_d;
  logic                                 baixa_q, baixa_d;
  logic                                 echo_sel;
  logic [DIST_W-1:0]                    min_v;

  assign echo_sel = sync2_q[idx_q];

  // Minimum over the channels whose last measurement was valid.
  always_comb begin
    min_v = '1;
    for (int i = 0; i < N_SENSORES; i++) begin
      if (valido_q[i] && (dist_q[i] < min_v)) min_v = dist_q[i];
    end
  end

  always_comb begin
    estado_d   = estado_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cm_d       = cm_q;
    timeout_d  = timeout_q;
    dist_d     = dist_q;
    valido_d   = valido_q;
    dist_min_d = dist_min_q;
    erro_d     = erro_q;
    abre_d     = abre_q;
    fecha_d    = fecha_q;
    alta_d     = alta_q;
    baixa_d    = baixa_q;
    unique case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        idx_d     = '0;
        cnt_d     = '0;
        cm_d      = '0;
        timeout_d = 1'b0;
        estado_d  = TRIGGER;
      end
      TRIGGER: begin
        if (cnt_q == TRIG_FIM) begin
          cnt_d    = '0;
          estado_d = ESPERA_ECHO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ESPERA_ECHO: begin
        // The cycle that sees the echo high is already part of the pulse width.
        if (echo_sel) begin
          estado_d = MEDE;
          cnt_d    = (CICLOS_CM == 1) ? '0 : CNT_W'(1);
          cm_d     = (CICLOS_CM == 1) ? DIST_W'(1) : '0;
        end else if (cnt_q == TIMEOUT_FIM) begin
          timeout_d = 1'b1;
          estado_d  = ARMAZENA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEDE: begin
        if (!echo_sel) begin
          estado_d = ARMAZENA;
        end else if (cnt_q == CM_FIM) begin
          cnt_d = '0;
          cm_d  = cm_q + DIST_W'(1);
          if (cm_q == MAX_D_M1) estado_d = ARMAZENA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARMAZENA: begin
        dist_d[idx_q]   = timeout_q ? MAX_D : cm_q;
        valido_d[idx_q] = !timeout_q;
        cnt_d           = '0;
        estado_d        = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_FIM) begin
          cnt_d     = '0;
          cm_d      = '0;
          timeout_d = 1'b0;
          if (idx_q == IDX_ULT) begin
            estado_d = AVALIA;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            estado_d = TRIGGER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      AVALIA: begin
        erro_d = ~|valido_q;
        // With no valid channel every derived output keeps its last value.
        if (|valido_q) begin
          dist_min_d = min_v;
          if (min_v >= ABRE_D) begin
            abre_d  = 1'b1;
            fecha_d = 1'b0;
          end else if (min_v <= FECHA_D) begin
            abre_d  = 1'b0;
            fecha_d = 1'b1;
          end
          alta_d  = (min_v <= ALTA_D);
          baixa_d = (min_v >= BAIXA_D);
        end
        estado_d = FIM;
      end
      FIM:     estado_d = continuo ? PREPARA : INICIAL;
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      idx_q      <= '0;
      cnt_q      <= '0;
      cm_q       <= '0;
      timeout_q  <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      dist_q     <= '0;
      valido_q   <= '0;
      dist_min_q <= '0;
      erro_q     <= 1'b0;
      abre_q     <= 1'b0;
      fecha_q    <= 1'b1;
      alta_q     <= 1'b0;
      baixa_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cm_q       <= cm_d;
      timeout_q  <= timeout_d;
      sync1_q    <= echo;
      sync2_q    <= sync1_q;
      dist_q     <= dist_d;
      valido_q   <= valido_d;
      dist_min_q <= dist_min_d;
      erro_q     <= erro_d;
      abre_q     <= abre_d;
      fecha_q    <= fecha_d;
      alta_q     <= alta_d;
      baixa_q    <= baixa_d;
    end
  end

  always_comb begin
    trigger = '0;
    if (estado_q == TRIGGER) trigger[idx_q] = 1'b1;
  end

  assign distancia     = dist_q;
  assign valido        = valido_q;
  assign dist_min      = dist_min_q;
  assign erro_sensor   = erro_q;
  assign abre_valvula  = abre_q;
  assign fecha_valvula = fecha_q;
  assign buzzer_alta   = alta_q;
  assign buzzer_baixa  = baixa_q;
  assign pronto        = (estado_q == FIM);
  assign db_fim_medida = (estado_q == ARMAZENA);
  assign db_estado     = estado_q;
  assign db_sensor     = 4'(idx_q);

endmodule

// File: tb/tb_medidor_multicanal.sv
// Self-checking bench for medidor_multicanal: emulated sensors answer each trigger with an echo of
// chosen width; round results are compared with a table and a distance/hysteresis reference model.
module tb_medidor_multicanal;
  localparam int N = 3;
  localparam int W = 12;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             iniciar = 1'b0;
  logic             continuo = 1'b0;
  logic [N-1:0]     echo = '0;
  logic [N-1:0]     trigger;
  logic [N*W-1:0]   distancia;
  logic [N-1:0]     valido;
  logic [W-1:0]     dist_min;
  logic             erro_sensor, abre_valvula, fecha_valvula, buzzer_alta, buzzer_baixa;
  logic             pronto, db_fim_medida;
  logic [3:0]       db_estado, db_sensor;

  medidor_multicanal #(
    .N_SENSORES(3), .DIST_W(12), .TRIG_CICLOS(5), .CICLOS_CM(10), .MAX_CM(40),
    .GAP_CICLOS(4), .DIST_ABRE(30), .DIST_FECHA(5), .DIST_ALTA(3), .DIST_BAIXA(35)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo), .echo(echo),
    .trigger(trigger), .distancia(distancia), .valido(valido), .dist_min(dist_min),
    .erro_sensor(erro_sensor), .abre_valvula(abre_valvula), .fecha_valvula(fecha_valvula),
    .buzzer_alta(buzzer_alta), .buzzer_baixa(buzzer_baixa), .pronto(pronto),
    .db_fim_medida(db_fim_medida), .db_estado(db_estado), .db_sensor(db_sensor)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int w0, w1, w2;
    int d0, d1, d2;
    logic [2:0] v;
    int mn;
    bit erro, abre, fecha, alta, baixa;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fim_cnt = 0;
  int st[3];
  int en[3];
  int m_min;
  bit m_abre, m_fecha, m_alta, m_baixa;
  vec_t tbl[9];

  // Sensor emulation: echo[i] is high for cycles st[i] <= cyc < en[i].
  initial begin
    for (int i = 0; i < 3; i++) begin st[i] = 0; en[i] = 0; end
    forever begin
      @(negedge clock);
      cyc++;
      for (int i = 0; i < 3; i++) echo[i] = (cyc >= st[i]) && (cyc < en[i]);
      if (db_fim_medida) fim_cnt++;
    end
  end

  function automatic vec_t mk(int w0, int w1, int w2, int d0, int d1, int d2, logic [2:0] v,
                              int mn, bit er, bit ab, bit fe, bit al, bit ba);
    vec_t r;
    r.w0 = w0; r.w1 = w1; r.w2 = w2; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.v = v; r.mn = mn;
    r.erro = er; r.abre = ab; r.fecha = fe; r.alta = al; r.baixa = ba;
    return r;
  endfunction

  function automatic int dist_of(int w);
    if (w == 0) return 40;
    return (w / 10 > 40) ? 40 : w / 10;
  endfunction

  // Reference: distance in cm from echo width, then min / hysteresis / alarms from plain rules.
  task automatic model_round(input int w0, input int w1, input int w2, output vec_t e);
    int d[3];
    int w[3];
    int mn;
    bit any;
    w[0] = w0; w[1] = w1; w[2] = w2;
    mn = 1 << 30;
    any = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = dist_of(w[i]);
      if (w[i] != 0) begin any = 1; if (d[i] < mn) mn = d[i]; end
    end
    if (any) begin
      m_min = mn;
      if (mn >= 30) begin m_abre = 1; m_fecha = 0; end
      else if (mn <= 5) begin m_abre = 0; m_fecha = 1; end
      m_alta  = (mn <= 3);
      m_baixa = (mn >= 35);
    end
    e = mk(w0, w1, w2, d[0], d[1], d[2], {w2 != 0, w1 != 0, w0 != 0}, m_min, !any,
           m_abre, m_fecha, m_alta, m_baixa);
  endtask

  function automatic int rand_w();
    if ($urandom_range(0, 9) == 0) return 0;
    return int'($urandom_range(1, 460));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic abort_run(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait expired without the expected event (cycle %0d)", nm, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic wait_trig(input logic [2:0] val, input string nm);
    int n = 0;
    while (trigger != val && n < 3000) begin @(negedge clock); n++; end
    if (trigger != val) abort_run(nm);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_estado"}, db_estado, 0);
    chk({tag, "_sensor"}, db_sensor, 0);
    chk({tag, "_trigger"}, trigger, 0);
    chk({tag, "_distancia_nz"}, int'(distancia != '0), 0);
    chk({tag, "_valido"}, valido, 0);
    chk({tag, "_dist_min"}, dist_min, 0);
    chk({tag, "_erro"}, erro_sensor, 0);
    chk({tag, "_abre"}, abre_valvula, 0);
    chk({tag, "_fecha"}, fecha_valvula, 1);
    chk({tag, "_alta"}, buzzer_alta, 0);
    chk({tag, "_baixa"}, buzzer_baixa, 0);
    chk({tag, "_pronto"}, pronto, 0);
    chk({tag, "_fim"}, db_fim_medida, 0);
  endtask

  task automatic run_round(input bit start, input vec_t e, input bit early0, input bit spur,
                           input string tag);
    int w[3];
    int n;
    bit cont_exp;
    w[0] = e.w0; w[1] = e.w1; w[2] = e.w2;
    fim_cnt = 0;
    if (start) begin
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
    end
    for (int ch = 0; ch < 3; ch++) begin
      n = 0;
      while (trigger == '0 && n < 3000) begin @(negedge clock); n++; end
      if (trigger == '0) abort_run({tag, "_trigger_wait"});
      chk($sformatf("%s_trig_sel%0d", tag, ch), trigger, 1 << ch);
      if (ch == 0 && early0) begin st[0] = cyc + 1; en[0] = st[0] + w[0]; end
      if (ch == 0 && spur) begin st[2] = cyc + 20; en[2] = cyc + 70; end
      n = 0;
      while (trigger == (3'b001 << ch) && n < 100) begin @(negedge clock); n++; end
      chk($sformatf("%s_trig_len%0d", tag, ch), n, 5);
      if (!(ch == 0 && early0)) begin
        if (w[ch] == 0) begin
          st[ch] = 0; en[ch] = 0;
        end else begin
          st[ch] = cyc + int'($urandom_range(1, 15));
          en[ch] = st[ch] + w[ch];
        end
      end
    end
    n = 0;
    while (!pronto && n < 3000) begin @(negedge clock); n++; end
    if (!pronto) abort_run({tag, "_pronto_wait"});
    chk({tag, "_dist0"}, int'(distancia[0 +: W]), e.d0);
    chk({tag, "_dist1"}, int'(distancia[W +: W]), e.d1);
    chk({tag, "_dist2"}, int'(distancia[2*W +: W]), e.d2);
    chk({tag, "_valido"}, valido, e.v);
    chk({tag, "_dist_min"}, dist_min, e.mn);
    chk({tag, "_erro"}, erro_sensor, e.erro);
    chk({tag, "_abre"}, abre_valvula, e.abre);
    chk({tag, "_fecha"}, fecha_valvula, e.fecha);
    chk({tag, "_exclusiva"}, abre_valvula & fecha_valvula, 0);
    chk({tag, "_alta"}, buzzer_alta, e.alta);
    chk({tag, "_baixa"}, buzzer_baixa, e.baixa);
    chk({tag, "_fim_pulsos"}, fim_cnt, 3);
    cont_exp = continuo;
    @(negedge clock);
    chk({tag, "_pronto_pulso"}, pronto, 0);
    chk({tag, "_estado_pos_fim"}, db_estado, cont_exp ? 1 : 0);
    $display("%s: widths %0d/%0d/%0d -> dist %0d/%0d/%0d valido %b min %0d abre %0d fecha %0d",
             tag, e.w0, e.w1, e.w2, distancia[0 +: W], distancia[W +: W], distancia[2*W +: W],
             valido, dist_min, abre_valvula, fecha_valvula);
  endtask

  initial begin
    vec_t e;
    int n;
    int bad;

    tbl[0] = mk(120, 250,  80, 12, 25,  8, 3'b111,  8, 0, 0, 1, 0, 0);
    tbl[1] = mk(150,   0, 330, 15, 40, 33, 3'b101, 15, 0, 0, 1, 0, 0);
    tbl[2] = mk(320, 350, 400, 32, 35, 40, 3'b111, 32, 0, 1, 0, 0, 0);
    tbl[3] = mk(200, 300, 250, 20, 30, 25, 3'b111, 20, 0, 1, 0, 0, 0);
    tbl[4] = mk( 45, 100, 200,  4, 10, 20, 3'b111,  4, 0, 0, 1, 0, 0);
    tbl[5] = mk(200, 210, 220, 20, 21, 22, 3'b111, 20, 0, 0, 1, 0, 0);
    tbl[6] = mk(  0,   0,   0, 40, 40, 40, 3'b000, 20, 1, 0, 1, 0, 0);
    tbl[7] = mk( 30, 395,  38,  3, 39,  3, 3'b111,  3, 0, 0, 1, 1, 0);
    tbl[8] = mk(500, 370, 360, 40, 37, 36, 3'b111, 36, 0, 1, 0, 0, 1);

    repeat (3) @(negedge clock);
    check_reset("reset_inicial");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 9; i++) run_round(1'b1, tbl[i], 1'b0, 1'b0, $sformatf("tabela%0d", i));
    m_min = 36; m_abre = 1; m_fecha = 0; m_alta = 0; m_baixa = 1;

    // Echo already high at ESPERA_ECHO entry, plus a spurious pulse on an unselected channel.
    model_round(125, 90, 200, e);
    run_round(1'b1, e, 1'b1, 1'b1, "echo_antecipado");

    // Back-to-back rounds, then return to idle.
    continuo = 1'b1;
    model_round(rand_w(), rand_w(), rand_w(), e);
    run_round(1'b1, e, 1'b0, 1'b0, "continuo_a");
    continuo = 1'b0;
    model_round(rand_w(), rand_w(), rand_w(), e);
    run_round(1'b0, e, 1'b0, 1'b0, "continuo_b");
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (db_estado != 4'd0) bad++;
      @(negedge clock);
    end
    chk("ocioso_sem_iniciar", bad, 0);

    for (int r = 0; r < 12; r++) begin
      model_round(rand_w(), rand_w(), rand_w(), e);
      run_round(1'b1, e, 1'b0, 1'b0, $sformatf("aleatorio%0d", r));
    end

    // Reset while measuring channel 1.
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    wait_trig(3'b001, "reset_trig0");
    wait_trig(3'b000, "reset_trig0_fim");
    st[0] = cyc + 2; en[0] = st[0] + 60;
    wait_trig(3'b010, "reset_trig1");
    wait_trig(3'b000, "reset_trig1_fim");
    st[1] = cyc + 2; en[1] = st[1] + 300;
    n = 0;
    while (db_estado != 4'd4 && n < 100) begin @(negedge clock); n++; end
    if (db_estado != 4'd4) abort_run("reset_mede_wait");
    repeat (20) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset("reset_em_mede");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin st[i] = 0; en[i] = 0; end
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      if (pronto || db_estado != 4'd0) bad++;
      @(negedge clock);
    end
    chk("sem_pronto_pos_reset", bad, 0);

    m_min = 0; m_abre = 0; m_fecha = 1; m_alta = 0; m_baixa = 0;
    model_round(rand_w(), rand_w(), rand_w(), e);
    run_round(1'b1, e, 1'b0, 1'b0, "pos_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
